four_adder: RTL and testbench
=============================

Name: four_adder

Overview:
- Registered 4-bit binary adder with carry-in and carry-out. Default width is 4 and can be changed by parameter.
- Built as a ripple-carry chain of 1-bit full-adder cells.
- Result is captured in output registers one clock after the operands are presented.
- Sits between the operand-capture logic (switch/key latches) and the 7-segment display mux. The display shows the sum nibble and the carry.

Parameters:
- WIDTH, 4, operand and sum width in bits; legal range 1 to 16.

Ports:
- clk  input  1  rising-edge system clock; the only clock.
- rst_n  input  1  synchronous reset, active-high despite the codebase name; sampled on rising clk.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- ci  input  1  carry-in, added at bit 0.
- in_valid  input  1  operands valid this cycle.
- s  output  WIDTH  registered sum, equal to (a+b+ci) mod 2^WIDTH.
- cout  output  1  registered carry-out, equal to bit WIDTH of a+b+ci.
- out_valid  output  1  s/cout updated from a valid input on the previous edge.
- ovf  output  1  registered two's-complement overflow; present only with FOUR_ADDER_OVF_EN.

Behaviour:
- Reset, when rst_n=1 at a rising edge: s=0, cout=0, out_valid=0, ovf=0. Reset has priority over in_valid in the same cycle.
- Combinational core is a ripple chain of WIDTH full-adder cells:
  - c[0]=ci.
  - s[i]=a[i]^b[i]^c[i].
  - c[i+1]=a[i]&b[i] | c[i]&(a[i]^b[i]).
  - cout=c[WIDTH].
- Latency is exactly 1 cycle. At a rising edge with in_valid=1, the registers load {cout,s}=a+b+ci, computed at WIDTH+1 bits with no truncation of the carry, and out_valid goes to 1.
- At a rising edge with in_valid=0: s and cout hold their previous values, and out_valid goes to 0 (single-cycle pulse per accepted operand set).
- No backpressure: a new operand set is accepted every cycle, and back-to-back in_valid gives back-to-back results.
- Boundary values for WIDTH=4:
  - a=F, b=F, ci=1 gives s=F, cout=1.
  - a=F, b=0, ci=1 gives wrap to s=0, cout=1.
  - a=0, b=0, ci=0 gives s=0, cout=0.
- Reset asserted mid-stream discards the in-flight result. The first valid input after reset releases produces a result on the following edge.
- Inputs are never X-propagated into state when in_valid=0.

Optional Feature:
- Macro: FOUR_ADDER_OVF_EN.
- Defined:
  - ovf port exists and is registered alongside s with the same enable and reset rules.
  - ovf = c[WIDTH] ^ c[WIDTH-1], i.e. signed overflow of a+b+ci.
- Undefined:
  - ovf port and its register are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package four_adder_pkg holds:
  - the default width constant ADD_W=4;
  - a typedef for the operand nibble;
  - the 7-segment lookup constant table for 0..F (3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71), used by the consuming display logic.
- One sub-module, fa_cell, is instantiated WIDTH times via generate:
  - inputs x, y, cin;
  - outputs sum, carry.
- four_adder contains only the generate chain, the output registers and out_valid.

Test Plan:
- Reset: drive rst_n=1 for 2 cycles with in_valid=1, a=5, b=3 -> s=0, cout=0, out_valid=0 throughout reset.
- Basic add: a=3, b=4, ci=0, in_valid=1 -> next edge s=7, cout=0, out_valid=1; the following idle cycle gives out_valid=0 with s still 7.
- Carry out: a=9, b=8, ci=0 -> s=1, cout=1. Then a=F, b=F, ci=1 -> s=F, cout=1.
- Carry-in wrap: a=F, b=0, ci=1 -> s=0, cout=1. Then a=0, b=0, ci=1 -> s=1, cout=0.
- Back-to-back and exhaustive: all 512 combinations of a, b, ci on consecutive cycles -> each result matches a+b+ci one cycle later, with out_valid held at 1.
- With FOUR_ADDER_OVF_EN: a=7, b=1, ci=0 -> s=8, ovf=1. a=8, b=8 -> s=0, cout=1, ovf=1. a=2, b=3 -> ovf=0.

Source files
------------

// File: rtl/four_adder_pkg.sv
// Shared constants and types for the registered adder and its display consumer.
package four_adder_pkg;

   localparam int ADD_W = 4;

   typedef logic [ADD_W-1:0] nibble_t;

   // Active-high segments {g,f,e,d,c,b,a} for hex digits 0..F.
   localparam logic [6:0] SEG_LUT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic logic [6:0] seg7(input nibble_t digit);
      return SEG_LUT[digit];
   endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder cell, the link of the ripple-carry chain.
module fa_cell (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic sum,
   output logic carry
);

   assign sum   = x ^ y ^ cin;
   assign carry = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/four_adder.sv
// Registered ripple-carry adder with carry-in/out and a one-cycle valid pulse.
// Define FOUR_ADDER_OVF_EN to add a registered signed-overflow output (ovf).
module four_adder
   import four_adder_pkg::*;
#(
   parameter int WIDTH = ADD_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             in_valid,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             out_valid
`ifdef FOUR_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] sum_next;
   logic [WIDTH-1:0] s_reg;
   logic             cout_reg;
   logic             valid_reg;

   assign c[0] = ci;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
         fa_cell u_fa (
            .x     (a[gi]),
            .y     (b[gi]),
            .cin   (c[gi]),
            .sum   (sum_next[gi]),
            .carry (c[gi+1])
         );
      end
   endgenerate

   // rst_n is active-high; s/cout only load on accepted operands so idle inputs never reach state.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         s_reg     <= '0;
         cout_reg  <= 1'b0;
         valid_reg <= 1'b0;
      end else begin
         valid_reg <= in_valid;
         if (in_valid) begin
            s_reg    <= sum_next;
            cout_reg <= c[WIDTH];
         end
      end
   end

   assign s         = s_reg;
   assign cout      = cout_reg;
   assign out_valid = valid_reg;

`ifdef FOUR_ADDER_OVF_EN
   logic ovf_reg;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         ovf_reg <= 1'b0;
      end else if (in_valid) begin
         ovf_reg <= c[WIDTH] ^ c[WIDTH-1];
      end
   end

   assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_four_adder.sv
// Directed and exhaustive checks of four_adder at WIDTH=4.
module tb_four_adder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] a;
   logic [3:0] b;
   logic       ci;
   logic       in_valid;
   logic [3:0] s;
   logic       cout;
   logic       out_valid;
`ifdef FOUR_ADDER_OVF_EN
   logic       ovf;
`endif

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   four_adder #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .ci        (ci),
      .in_valid  (in_valid),
      .s         (s),
      .cout      (cout),
      .out_valid (out_valid)
`ifdef FOUR_ADDER_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Present one operand set at the falling edge, then sample just after the next rising edge.
   task automatic step(input logic [3:0] av, input logic [3:0] bv, input logic cv, input logic vv);
      @(negedge clk);
      a        = av;
      b        = bv;
      ci       = cv;
      in_valid = vv;
      @(posedge clk);
      #1;
      $display("txn a=%0h b=%0h ci=%0b v=%0b -> s=%0h cout=%0b out_valid=%0b",
               av, bv, cv, vv, s, cout, out_valid);
   endtask

   initial begin
      rst_n    = 1'b1;
      a        = 4'h5;
      b        = 4'h3;
      ci       = 1'b0;
      in_valid = 1'b1;

      // Reset wins over a valid operand set.
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         check("rst_s", 32'(s), 32'h0);
         check("rst_cout", 32'(cout), 32'h0);
         check("rst_valid", 32'(out_valid), 32'h0);
`ifdef FOUR_ADDER_OVF_EN
         check("rst_ovf", 32'(ovf), 32'h0);
`endif
      end
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b0;

      step(4'h3, 4'h4, 1'b0, 1'b1);
      check("basic_s", 32'(s), 32'h7);
      check("basic_cout", 32'(cout), 32'h0);
      check("basic_valid", 32'(out_valid), 32'h1);
      step(4'hA, 4'hA, 1'b1, 1'b0);
      check("idle_valid", 32'(out_valid), 32'h0);
      check("idle_hold_s", 32'(s), 32'h7);
      check("idle_hold_cout", 32'(cout), 32'h0);

      step(4'h9, 4'h8, 1'b0, 1'b1);
      check("carry98", 32'({cout, s}), 32'h11);
      step(4'hF, 4'hF, 1'b1, 1'b1);
      check("carryFF1", 32'({cout, s}), 32'h1F);
      step(4'hF, 4'h0, 1'b1, 1'b1);
      check("wrapF01", 32'({cout, s}), 32'h10);
      step(4'h0, 4'h0, 1'b1, 1'b1);
      check("cin001", 32'({cout, s}), 32'h01);
      step(4'h0, 4'h0, 1'b0, 1'b1);
      check("zero000", 32'({cout, s}), 32'h00);

      // Mid-stream reset discards the in-flight result.
      step(4'h6, 4'h6, 1'b0, 1'b1);
      check("pre_rst", 32'({cout, s}), 32'h0C);
      @(negedge clk);
      rst_n    = 1'b1;
      a        = 4'hE;
      b        = 4'h1;
      @(posedge clk);
      #1;
      check("mid_rst_s", 32'({cout, s}), 32'h00);
      check("mid_rst_valid", 32'(out_valid), 32'h0);
      @(negedge clk);
      rst_n = 1'b0;
      step(4'h2, 4'h5, 1'b0, 1'b1);
      check("post_rst", 32'({cout, s}), 32'h07);
      check("post_rst_valid", 32'(out_valid), 32'h1);

`ifdef FOUR_ADDER_OVF_EN
      step(4'h7, 4'h1, 1'b0, 1'b1);
      check("ovf71_s", 32'(s), 32'h8);
      check("ovf71", 32'(ovf), 32'h1);
      step(4'h8, 4'h8, 1'b0, 1'b1);
      check("ovf88_s", 32'({cout, s}), 32'h10);
      check("ovf88", 32'(ovf), 32'h1);
      step(4'h2, 4'h3, 1'b0, 1'b1);
      check("ovf23", 32'(ovf), 32'h0);
`endif

      // Every a,b,ci combination on back-to-back cycles.
      for (int k = 0; k < 512; k++) begin
         logic [3:0] av;
         logic [3:0] bv;
         logic       cv;
         logic [4:0] exp_sum;
         av      = 4'(k >> 5);
         bv      = 4'(k >> 1);
         cv      = k[0];
         exp_sum = 5'(int'(av) + int'(bv) + int'(cv));
         step(av, bv, cv, 1'b1);
         check("exh_sum", 32'({cout, s}), 32'(exp_sum));
         check("exh_valid", 32'(out_valid), 32'h1);
`ifdef FOUR_ADDER_OVF_EN
         check("exh_ovf", 32'(ovf), 32'((av[3] == bv[3]) && (exp_sum[3] != av[3])));
`endif
      end

      step(4'h0, 4'h0, 1'b0, 1'b0);
      check("tail_valid", 32'(out_valid), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
